branch_predictor_nbit: RTL and testbench

- Parametrised successor to the 1-bit branch unit.
- Holds a direct-mapped BTB with an N-bit saturating-counter direction predictor per entry.
- Fetch stage: looks up the predicted next-PC select combinationally.
- Resolve stage: compares the outcome against the prediction carried down an internal tracking pipe, then generates flush, redirect select and table updates.

---
 rtl/branch_predictor_nbit_if.sv | 42 ++++
 rtl/branch_predictor_nbit.sv | 165 ++++++++++++++++
 tb/tb_branch_predictor_nbit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_nbit_if.sv
// Fetch/resolve bundle for branch_predictor_nbit.
// BP_PERF_CNT_EN adds the br_count / mispred_count outputs.
interface branch_predictor_nbit_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              stall;
    logic              res_valid;
    logic              res_is_branch;
    logic              res_taken;
    logic [ADDR_W-1:0] res_pc;
    logic [ADDR_W-1:0] res_target;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [1:0]        mux_f;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_s1;
`ifdef BP_PERF_CNT_EN
    logic [31:0]       br_count;
    logic [31:0]       mispred_count;
`endif

    modport master (
        output fetch_valid, fetch_pc, stall, res_valid, res_is_branch,
               res_taken, res_pc, res_target,
        input  pred_hit, pred_taken, pred_target, mux_f, redirect_pc, flush_s1
`ifdef BP_PERF_CNT_EN
        , input br_count, mispred_count
`endif
    );

    modport slave (
        input  fetch_valid, fetch_pc, stall, res_valid, res_is_branch,
               res_taken, res_pc, res_target,
        output pred_hit, pred_taken, pred_target, mux_f, redirect_pc, flush_s1
`ifdef BP_PERF_CNT_EN
        , output br_count, mispred_count
`endif
    );
endinterface

// File: rtl/branch_predictor_nbit.sv
// Direct-mapped BTB with N-bit saturating direction counters and a fetch->resolve tracking pipe.
// Optional performance counters are enabled with BP_PERF_CNT_EN.
module branch_predictor_nbit #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CTR_W   = 2,
    parameter int RES_LAT = 1
) (
    input logic                  clk,
    input logic                  rst,
    branch_predictor_nbit_if.slave bp
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1'b1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1'b1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr, input logic taken);
        logic [CTR_W-1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != CTR_MAX)) begin
            nxt = ctr + CTR_W'(1'b1);
        end else if (!taken && (ctr != CTR_MIN)) begin
            nxt = ctr - CTR_W'(1'b1);
        end else begin
            nxt = ctr;
        end
        return nxt;
    endfunction

    logic [DEPTH-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_r [DEPTH];
    logic [ADDR_W-1:0]  tgt_r [DEPTH];
    logic [CTR_W-1:0]   ctr_r [DEPTH];
    logic [RES_LAT-1:0] pv_r;
    logic [RES_LAT-1:0] ph_r;
    logic [RES_LAT-1:0] pt_r;

    logic [IDX_W-1:0]  f_idx_s;
    logic [TAG_W-1:0]  f_tag_s;
    logic [IDX_W-1:0]  r_idx_s;
    logic [TAG_W-1:0]  r_tag_s;
    logic              hit_s;
    logic              taken_s;
    logic              event_s;
    logic              mispred_s;
    logic              upd_match_s;
    logic              flush_s;
    logic [1:0]        mux_s;
    logic [ADDR_W-1:0] redir_s;
    logic              unused_s;

    assign f_idx_s  = bp.fetch_pc[IDX_W+1:2];
    assign f_tag_s  = bp.fetch_pc[ADDR_W-1:IDX_W+2];
    assign r_idx_s  = bp.res_pc[IDX_W+1:2];
    assign r_tag_s  = bp.res_pc[ADDR_W-1:IDX_W+2];
    assign unused_s = ^{bp.fetch_pc[1:0], bp.res_pc[1:0]};

    // Reset forces the lookup to read as a miss.
    assign hit_s   = !rst && bp.fetch_valid && valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    assign taken_s = hit_s && ctr_r[f_idx_s][CTR_W-1];

    assign event_s     = !rst && bp.res_valid && bp.res_is_branch && pv_r[RES_LAT-1] && !bp.stall;
    assign mispred_s   = event_s && (bp.res_taken != pt_r[RES_LAT-1]);
    assign upd_match_s = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_tag_s);

    // Next-PC select: a resolve-stage redirect overrides the fetch prediction.
    always_comb begin
        flush_s = 1'b0;
        mux_s   = 2'b00;
        redir_s = {ADDR_W{1'b0}};
        if (mispred_s) begin
            flush_s = 1'b1;
            if (bp.res_taken) begin
                mux_s   = 2'b11;
                redir_s = bp.res_target;
            end else begin
                mux_s   = 2'b10;
                redir_s = bp.res_pc + ADDR_W'(3'd4);
            end
        end else if (taken_s) begin
            mux_s = 2'b01;
        end else begin
            mux_s = 2'b00;
        end
    end

    assign bp.pred_hit    = hit_s;
    assign bp.pred_taken  = taken_s;
    assign bp.pred_target = hit_s ? tgt_r[f_idx_s] : {ADDR_W{1'b0}};
    assign bp.flush_s1    = flush_s;
    assign bp.mux_f       = mux_s;
    assign bp.redirect_pc = redir_s;

    // Tracking pipe: a flush kills every in-flight stage and drops this cycle's fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_r <= {RES_LAT{1'b0}};
            ph_r <= {RES_LAT{1'b0}};
            pt_r <= {RES_LAT{1'b0}};
        end else if (flush_s) begin
            pv_r <= {RES_LAT{1'b0}};
        end else if (!bp.stall) begin
            pv_r[0] <= bp.fetch_valid;
            ph_r[0] <= hit_s;
            pt_r[0] <= taken_s;
            for (int i = 1; i < RES_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                ph_r[i] <= ph_r[i-1];
                pt_r[i] <= pt_r[i-1];
            end
        end
    end

    // BTB update; the tag is rechecked because the entry may have been reallocated in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
                tgt_r[i] <= {ADDR_W{1'b0}};
                ctr_r[i] <= CTR_WNT;
            end
        end else if (event_s) begin
            if (ph_r[RES_LAT-1] && upd_match_s) begin
                ctr_r[r_idx_s] <= ctr_step(ctr_r[r_idx_s], bp.res_taken);
                if (bp.res_taken) begin
                    tgt_r[r_idx_s] <= bp.res_target;
                end
            end else if (bp.res_taken) begin
                valid_r[r_idx_s] <= 1'b1;
                tag_r[r_idx_s]   <= r_tag_s;
                tgt_r[r_idx_s]   <= bp.res_target;
                ctr_r[r_idx_s]   <= CTR_WT;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_r;
    logic [31:0] mis_cnt_r;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r  <= 32'd0;
            mis_cnt_r <= 32'd0;
        end else begin
            if (event_s && (br_cnt_r != 32'hFFFF_FFFF)) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (mispred_s && (mis_cnt_r != 32'hFFFF_FFFF)) begin
                mis_cnt_r <= mis_cnt_r + 32'd1;
            end
        end
    end

    assign bp.br_count      = br_cnt_r;
    assign bp.mispred_count = mis_cnt_r;
`else
    // Counters absent; prediction and resolution behave identically.
`endif
endmodule

// File: tb/tb_branch_predictor_nbit.sv
// Directed vector table plus randomized run against a behavioural predictor model.
module tb_branch_predictor_nbit;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 16;
    localparam int CTR_W   = 2;
    localparam int RES_LAT = 1;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int NVEC    = 25;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_predictor_nbit_if #(.ADDR_W(ADDR_W)) bp ();

    branch_predictor_nbit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CTR_W(CTR_W), .RES_LAT(RES_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit fv; bit [31:0] fpc; bit stall;
        bit rv; bit rb; bit rt; bit [31:0] rpc; bit [31:0] rtgt;
        bit hit; bit tk; bit [31:0] tgt; bit [1:0] mux; bit [31:0] red; bit fl;
    } vec_t;
    vec_t vt [NVEC];

    typedef struct { bit v; bit hit; bit taken; } stage_t;

    // behavioural model state
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    bit [31:0]   m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    stage_t      m_pipe  [$];
    longint      m_br;
    longint      m_mis;
    bit          e_hit, e_tk, e_fl, e_ev, e_misp;
    bit [31:0]   e_tgt, e_red;
    bit [1:0]    e_mux;

    function automatic vec_t mk(bit r, bit fv, bit [31:0] fpc, bit st, bit rv, bit rb, bit rt,
                                bit [31:0] rpc, bit [31:0] rtgt, bit hit, bit tk, bit [31:0] tgt,
                                bit [1:0] mux, bit [31:0] red, bit fl);
        vec_t v;
        v.rst = r; v.fv = fv; v.fpc = fpc; v.stall = st; v.rv = rv; v.rb = rb; v.rt = rt;
        v.rpc = rpc; v.rtgt = rtgt; v.hit = hit; v.tk = tk; v.tgt = tgt; v.mux = mux;
        v.red = red; v.fl = fl;
        return v;
    endfunction

    task automatic chk(string name, bit [31:0] act, bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(bit [31:0] pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(bit [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 2 ** (CTR_W - 1) - 1;
        end
        m_pipe.delete();
        for (int i = 0; i < RES_LAT; i++) m_pipe.push_back('{v: 1'b0, hit: 1'b0, taken: 1'b0});
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_eval();
        int unsigned fi;
        stage_t      tl;
        fi     = idx_of(bp.fetch_pc);
        tl     = m_pipe[$];
        e_hit  = !rst && bp.fetch_valid && m_valid[fi] && (m_tag[fi] == tag_of(bp.fetch_pc));
        e_tk   = e_hit && (m_ctr[fi] >= 2 ** (CTR_W - 1));
        e_tgt  = e_hit ? m_tgt[fi] : 32'd0;
        e_ev   = !rst && bp.res_valid && bp.res_is_branch && tl.v && !bp.stall;
        e_misp = e_ev && (bp.res_taken != tl.taken);
        e_fl   = e_misp;
        e_red  = 32'd0;
        if (e_misp) begin
            e_mux = bp.res_taken ? 2'b11 : 2'b10;
            e_red = bp.res_taken ? bp.res_target : bp.res_pc + 32'd4;
        end else begin
            e_mux = e_tk ? 2'b01 : 2'b00;
        end
    endtask

    task automatic model_update();
        int unsigned ri;
        stage_t      tl;
        if (rst) begin
            model_reset();
            return;
        end
        tl = m_pipe[$];
        ri = idx_of(bp.res_pc);
        if (e_ev) begin
            m_br++;
            if (e_misp) m_mis++;
            if (tl.hit && m_valid[ri] && m_tag[ri] == tag_of(bp.res_pc)) begin
                if (bp.res_taken) begin
                    m_ctr[ri] = (m_ctr[ri] + 1 > 2 ** CTR_W - 1) ? 2 ** CTR_W - 1 : m_ctr[ri] + 1;
                    m_tgt[ri] = bp.res_target;
                end else begin
                    m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
                end
            end else if (bp.res_taken) begin
                m_valid[ri] = 1'b1;
                m_tag[ri]   = tag_of(bp.res_pc);
                m_tgt[ri]   = bp.res_target;
                m_ctr[ri]   = 2 ** (CTR_W - 1);
            end
        end
        if (e_misp) begin
            foreach (m_pipe[i]) m_pipe[i].v = 1'b0;
        end else if (!bp.stall) begin
            m_pipe.push_front('{v: bp.fetch_valid, hit: e_hit, taken: e_tk});
            void'(m_pipe.pop_back());
        end
    endtask

    task automatic drive(bit r, bit fv, bit [31:0] fpc, bit st, bit rv, bit rb, bit rt,
                         bit [31:0] rpc, bit [31:0] rtgt);
        rst = r;
        bp.fetch_valid = fv; bp.fetch_pc = fpc; bp.stall = st;
        bp.res_valid = rv; bp.res_is_branch = rb; bp.res_taken = rt;
        bp.res_pc = rpc; bp.res_target = rtgt;
    endtask

    bit [31:0] pool [8];

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();

        //         rst fv  fpc        st  rv  rb  rt  rpc        rtgt        hit tk  tgt        mux    red        fl
        vt[0]  = mk(1, 1, 32'h40,   0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[1]  = mk(0, 1, 32'h40,   0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[2]  = mk(0, 0, 32'h0,    0, 1, 1, 1, 32'h40,  32'h100,   0, 0, 32'h0,   2'b11, 32'h100, 1);
        vt[3]  = mk(0, 1, 32'h40,   0, 0, 0, 0, 32'h0,   32'h0,     1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[4]  = mk(0, 0, 32'h0,    0, 1, 1, 0, 32'h40,  32'h100,   0, 0, 32'h0,   2'b10, 32'h44,  1);
        vt[5]  = mk(0, 1, 32'h40,   0, 0, 0, 0, 32'h0,   32'h0,     1, 0, 32'h100, 2'b00, 32'h0,   0);
        vt[6]  = mk(0, 1, 32'h40,   0, 1, 1, 1, 32'h40,  32'h100,   1, 0, 32'h100, 2'b11, 32'h100, 1);
        vt[7]  = mk(0, 1, 32'h40,   0, 1, 1, 1, 32'h40,  32'h100,   1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[8]  = mk(0, 1, 32'h40,   0, 1, 1, 1, 32'h40,  32'h100,   1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[9]  = mk(0, 1, 32'h40,   0, 1, 1, 1, 32'h40,  32'h100,   1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[10] = mk(0, 1, 32'h40,   0, 1, 1, 1, 32'h40,  32'h100,   1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[11] = mk(0, 1, 32'h40,   0, 1, 1, 0, 32'h40,  32'h100,   1, 1, 32'h100, 2'b10, 32'h44,  1);
        vt[12] = mk(0, 1, 32'h40,   0, 0, 0, 0, 32'h0,   32'h0,     1, 1, 32'h100, 2'b01, 32'h0,   0);
        vt[13] = mk(0, 1, 32'h440,  0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[14] = mk(0, 0, 32'h0,    0, 1, 1, 1, 32'h440, 32'h200,   0, 0, 32'h0,   2'b11, 32'h200, 1);
        vt[15] = mk(0, 0, 32'h0,    0, 1, 1, 1, 32'h84,  32'h300,   0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[16] = mk(0, 1, 32'h84,   0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[17] = mk(0, 1, 32'h440,  0, 0, 0, 0, 32'h0,   32'h0,     1, 1, 32'h200, 2'b01, 32'h0,   0);
        vt[18] = mk(0, 1, 32'h84,   1, 1, 1, 0, 32'h440, 32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[19] = mk(0, 0, 32'h0,    0, 1, 1, 0, 32'h440, 32'h0,     0, 0, 32'h0,   2'b10, 32'h444, 1);
        vt[20] = mk(0, 1, 32'h440,  0, 0, 0, 0, 32'h0,   32'h0,     1, 0, 32'h200, 2'b00, 32'h0,   0);
        vt[21] = mk(1, 1, 32'h440,  0, 1, 1, 1, 32'h440, 32'h500,   0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[22] = mk(0, 1, 32'h440,  0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[23] = mk(0, 0, 32'h0,    0, 1, 0, 1, 32'h440, 32'h500,   0, 0, 32'h0,   2'b00, 32'h0,   0);
        vt[24] = mk(0, 1, 32'h440,  0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 32'h0,   2'b00, 32'h0,   0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].fv, vt[i].fpc, vt[i].stall, vt[i].rv, vt[i].rb, vt[i].rt,
                  vt[i].rpc, vt[i].rtgt);
            #4;
            model_eval();
            chk($sformatf("v%0d_hit", i),   32'(bp.pred_hit),    32'(vt[i].hit));
            chk($sformatf("v%0d_taken", i), 32'(bp.pred_taken),  32'(vt[i].tk));
            chk($sformatf("v%0d_target", i), bp.pred_target,     vt[i].tgt);
            chk($sformatf("v%0d_mux", i),   32'(bp.mux_f),       32'(vt[i].mux));
            chk($sformatf("v%0d_redir", i), bp.redirect_pc,      vt[i].red);
            chk($sformatf("v%0d_flush", i), 32'(bp.flush_s1),    32'(vt[i].fl));
            @(posedge clk);
            model_update();
        end

        // randomized run against the model; small PC pool forces aliasing and reuse
        pool[0] = 32'h40;  pool[1] = 32'h440; pool[2] = 32'h84;  pool[3] = 32'h884;
        pool[4] = 32'h100; pool[5] = 32'hC0;  pool[6] = 32'h4C0; pool[7] = 32'h3FC;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive((n == 0) || ($urandom_range(0, 149) == 0),
                  $urandom_range(0, 3) != 0, pool[$urandom_range(0, 7)],
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                  pool[$urandom_range(0, 7)], $urandom() & 32'hFFFF_FFFC);
            #4;
            model_eval();
            chk("rnd_hit",    32'(bp.pred_hit),   32'(e_hit));
            chk("rnd_taken",  32'(bp.pred_taken), 32'(e_tk));
            chk("rnd_target", bp.pred_target,     e_tgt);
            chk("rnd_mux",    32'(bp.mux_f),      32'(e_mux));
            chk("rnd_redir",  bp.redirect_pc,     e_red);
            chk("rnd_flush",  32'(bp.flush_s1),   32'(e_fl));
`ifdef BP_PERF_CNT_EN
            chk("rnd_br_count",  bp.br_count,      32'(m_br));
            chk("rnd_mis_count", bp.mispred_count, 32'(m_mis));
`endif
            @(posedge clk);
            model_update();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
